// File: rtl/bram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_if
// Valid/ready stream carrying words read out of the block RAM.
//   data_out  : stream word (FIFO head), RAM_WIDTH bits
//   valid_out : a word is being offered
//   last_out  : offered word is the final one of the transfer
//   ready_in  : downstream accepts the offered word this cycle
// The master modport is the reader (producer); the slave modport is the
// downstream consumer.
// -----------------------------------------------------------------------------
interface bram_stream_reader_if #(
    parameter int RAM_WIDTH = 18
);
    logic [RAM_WIDTH-1:0] data_out;
    logic                 valid_out;
    logic                 last_out;
    logic                 ready_in;

    modport master (
        output data_out,
        output valid_out,
        output last_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  valid_out,
        input  last_out,
        output ready_in
    );
endinterface

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Turns the fixed-latency, non-stallable read port of a single-port block RAM
// into a valid/ready stream. A transfer reads len_in consecutive words starting
// at base_addr_in (wrapping past RAM_DEPTH-1 to 0). Reads are only issued while
// the words already buffered plus the words still in the RAM pipeline leave
// room in the output FIFO, so returning data is always captured.
//
// Ports:
//   clka, rsta_n        clock, asynchronous active-low reset
//   start_in            start a transfer (only looked at while idle)
//   base_addr_in        first RAM address
//   len_in              number of words, 0..RAM_DEPTH
//   busy_out            transfer in progress
//   done_out            one-cycle pulse after the transfer finishes
//   ram_*               block RAM port A controls and read data
//   strm                output stream (master side)
// -----------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    input  logic                 start_in,
    input  logic [ADDR_W-1:0]    base_addr_in,
    input  logic [ADDR_W:0]      len_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [ADDR_W-1:0]    ram_addra_out,
    output logic                 ram_ena_out,
    output logic                 ram_wea_out,
    output logic                 ram_regcea_out,
    output logic                 ram_rsta_out,
    input  logic [RAM_WIDTH-1:0] ram_douta_in,
    bram_stream_reader_if.master strm
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    localparam logic [OCC_W-1:0]  OCC_LIMIT = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Next RAM address; compare-based wrap so non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] n;
        if (a == ADDR_LAST) begin
            n = '0;
        end else begin
            n = a + ADDR_ONE;
        end
        return n;
    endfunction

    // Number of reads still travelling through the RAM pipeline.
    function automatic logic [OCC_W-1:0] tag_count(input logic [READ_LATENCY-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W:0]        rem_q, rem_d;
    logic                   ena_q, ena_d;
    logic                   done_q, done_d;
    logic [READ_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [READ_LATENCY-1:0] tag_l_q, tag_l_d;
    logic [RAM_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  last_mem_q;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       cnt_q, cnt_d;
    logic                   push_s, pop_s, valid_s, head_last_s;

    assign valid_s     = (cnt_q != '0);
    assign head_last_s = last_mem_q[rd_ptr_q];

    // Next-state for the sequencer, tag pipeline and FIFO bookkeeping.
    always_comb begin
        // A tag leaving the last stage means its word is on ram_douta_in now.
        push_s = tag_v_q[READ_LATENCY-1];
        pop_s  = valid_s & strm.ready_in;

        tag_v_d[0] = ena_q;
        tag_l_d[0] = ena_q & (rem_q == REM_ONE);
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_l_d[i] = tag_l_q[i-1];
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + OCC_ONE;
            2'b01:   cnt_d = cnt_q - OCC_ONE;
            default: cnt_d = cnt_q;
        endcase

        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    if (len_in != '0) begin
                        state_d = ST_ISSUE;
                        addr_d  = base_addr_in;
                        rem_d   = len_in;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // ena_q high means the read at addr_q is being issued now.
                if (ena_q) begin
                    addr_d = addr_next(addr_q);
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The enable is registered, so the credit check is made against the
        // occupancy the FIFO and pipeline will have in the cycle of the issue.
        if ((state_d == ST_ISSUE) && ((cnt_d + tag_count(tag_v_d)) < OCC_LIMIT)) begin
            ena_d = 1'b1;
        end else begin
            ena_d = 1'b0;
        end
    end

    // State, control and FIFO storage registers.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            ena_q      <= 1'b0;
            done_q     <= 1'b0;
            tag_v_q    <= '0;
            tag_l_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_mem_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            ena_q    <= ena_d;
            done_q   <= done_d;
            tag_v_q  <= tag_v_d;
            tag_l_q  <= tag_l_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_s) begin
                mem_q[wr_ptr_q]      <= ram_douta_in;
                last_mem_q[wr_ptr_q] <= tag_l_q[READ_LATENCY-1];
            end else begin
                last_mem_q <= last_mem_q;
            end
        end
    end

    assign busy_out       = (state_q != ST_IDLE);
    assign done_out       = done_q;
    assign ram_addra_out  = addr_q;
    assign ram_ena_out    = ena_q;
    assign ram_wea_out    = 1'b0;
    assign ram_rsta_out   = 1'b0;
    assign ram_regcea_out = rsta_n;

    assign strm.data_out  = mem_q[rd_ptr_q];
    assign strm.valid_out = valid_s;
    assign strm.last_out  = head_last_s & valid_s;

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Bench for bram_stream_reader. Instance A uses READ_LATENCY=2 against a
// HIGH_PERFORMANCE style RAM model; instance B uses READ_LATENCY=1 against a
// LOW_LATENCY style RAM model. Expected beats for A come from the bench RAM
// array: a transfer (base, len) must deliver ram[(base+i) % DEPTH] in order,
// last flagged on the final word, with issued-minus-delivered never above the
// FIFO depth.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_stream_reader;

    localparam int W  = 18;
    localparam int D  = 1024;
    localparam int AW = 10;
    localparam int FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // ---------------- instance A (READ_LATENCY = 2) ----------------
    logic          start_a;
    logic [AW-1:0] base_a;
    logic [AW:0]   len_a;
    logic          busy_a, done_a, ena_a, wea_a, regcea_a, rsta_a;
    logic [AW-1:0] addr_a;
    logic [W-1:0]  douta_a;
    logic [W-1:0]  ra_s1;

    bram_stream_reader_if #(.RAM_WIDTH(W)) sa ();

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_W(AW),
                         .READ_LATENCY(2), .FIFO_DEPTH(FD)) dut_a (
        .clka(clk), .rsta_n(rst_n), .start_in(start_a), .base_addr_in(base_a),
        .len_in(len_a), .busy_out(busy_a), .done_out(done_a),
        .ram_addra_out(addr_a), .ram_ena_out(ena_a), .ram_wea_out(wea_a),
        .ram_regcea_out(regcea_a), .ram_rsta_out(rsta_a),
        .ram_douta_in(douta_a), .strm(sa)
    );

    // ---------------- instance B (READ_LATENCY = 1) ----------------
    logic          start_b;
    logic [AW-1:0] base_b;
    logic [AW:0]   len_b;
    logic          busy_b, done_b, ena_b, wea_b, regcea_b, rsta_b;
    logic [AW-1:0] addr_b;
    logic [W-1:0]  douta_b;

    bram_stream_reader_if #(.RAM_WIDTH(W)) sb ();
    assign sb.ready_in = 1'b1;

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_W(AW),
                         .READ_LATENCY(1), .FIFO_DEPTH(FD)) dut_b (
        .clka(clk), .rsta_n(rst_n), .start_in(start_b), .base_addr_in(base_b),
        .len_in(len_b), .busy_out(busy_b), .done_out(done_b),
        .ram_addra_out(addr_b), .ram_ena_out(ena_b), .ram_wea_out(wea_b),
        .ram_regcea_out(regcea_b), .ram_rsta_out(rsta_b),
        .ram_douta_in(douta_b), .strm(sb)
    );

    // ---------------- RAM models ----------------
    logic [W-1:0] ram [D];

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Read-first RAM with output register (two-cycle read).
    always @(posedge clk) begin
        if (ena_a) ra_s1 <= ram[addr_a];
        if (regcea_a) douta_a <= ra_s1;
    end

    // Read-first RAM without output register (one-cycle read).
    always @(posedge clk) begin
        if (ena_b) douta_b <= ram[addr_b];
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    bit    done_at[int];
    int    m_base, m_len, m_issued, m_popped, m_start_cyc, m_done_last;
    bit    m_active;

    int    ena_cnt, first_ena, last_ena, first_valid, last_pop_cyc, done_seen;
    logic [W-1:0] first_data, last_data;
    int    addr_log[$];

    int    rmode = 0;
    logic [3:0] rpat = 4'b1001;

    // Downstream ready: 0 always, 1 pattern 1,0,0,1, 2 random, 3 never.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       sa.ready_in = 1'b1;
            1:       sa.ready_in = rpat[cyc % 4];
            2:       sa.ready_in = ($urandom_range(0, 3) != 0);
            default: sa.ready_in = 1'b0;
        endcase
    end

    logic         prev_hold;
    logic [W-1:0] prev_data;
    logic         prev_last;

    // Per-cycle comparison of instance A against the model.
    always @(negedge clk) begin : cmp_a
        beat_t bt;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (ena_a) begin
                chk("addr", 32'(addr_a), 32'((m_base + m_issued) % D));
                chk("overissue", 32'(m_issued < m_len), 32'd1);
                addr_log.push_back(int'(addr_a));
                if (first_ena < 0) first_ena = cyc;
                last_ena = cyc;
                ena_cnt++;
                m_issued++;
            end
            chk("occupancy", 32'((m_issued - m_popped) <= FD), 32'd1);
            chk("busy", 32'(busy_a), 32'(m_active && (cyc > m_start_cyc)));
            chk("done", 32'(done_a), 32'(done_at.exists(cyc)));
            chk("valid_unexpected", 32'(sa.valid_out && (exp_q.size() == 0)), 32'd0);
            if (done_a) done_seen = cyc;
            if (prev_hold) begin
                chk("hold_valid", 32'(sa.valid_out), 32'd1);
                chk("hold_data", 32'(sa.data_out), 32'(prev_data));
                chk("hold_last", 32'(sa.last_out), 32'(prev_last));
            end
            if (sa.valid_out && (first_valid < 0)) first_valid = cyc;
            if (sa.valid_out && sa.ready_in && (exp_q.size() > 0)) begin
                bt = exp_q.pop_front();
                chk("data", 32'(sa.data_out), 32'(bt.data));
                chk("last", 32'(sa.last_out), 32'(bt.last));
                if (m_popped == 0) first_data = sa.data_out;
                last_data = sa.data_out;
                last_pop_cyc = cyc;
                m_popped++;
                if (bt.last) begin
                    m_active = 1'b0;
                    done_at[cyc + 1] = 1'b1;
                    m_done_last = cyc + 1;
                end
            end
            prev_hold = sa.valid_out & ~sa.ready_in;
            prev_data = sa.data_out;
            prev_last = sa.last_out;
        end
    end

    // ---------------- instance B beat log ----------------
    typedef struct {
        int           c;
        logic [W-1:0] d;
        logic         l;
    } bbeat_t;

    bbeat_t bq[$];
    int     b_first_ena = -1;
    int     b_done_seen = -1;

    // Record every beat instance B delivers.
    always @(negedge clk) begin : log_b
        bbeat_t e;
        if (rst_n) begin
            if (sb.valid_out) begin
                e.c = cyc;
                e.d = sb.data_out;
                e.l = sb.last_out;
                bq.push_back(e);
            end
            if (ena_b && (b_first_ena < 0)) b_first_ena = cyc;
            if (done_b) b_done_seen = cyc;
        end
    end

    // Present a start to instance A in the current cycle and load the model.
    task automatic kick(input int b, input int l);
        beat_t bt;
        start_a = 1'b1;
        base_a  = AW'(b);
        len_a   = (AW + 1)'(l);
        m_base = b; m_len = l; m_issued = 0; m_popped = 0; m_start_cyc = cyc;
        exp_q.delete();
        for (int i = 0; i < l; i++) begin
            bt.last = (i == l - 1);
            bt.data = ram[(b + i) % D];
            exp_q.push_back(bt);
        end
        if (l == 0) begin
            done_at[cyc + 1] = 1'b1;
            m_done_last = cyc + 1;
        end else begin
            m_active = 1'b1;
        end
        ena_cnt = 0; first_ena = -1; last_ena = -1; first_valid = -1;
        last_pop_cyc = -1; done_seen = -1;
        addr_log.delete();
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    // Return in the done cycle of the current transfer (or budget expiry).
    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || (exp_q.size() != 0) || (cyc < m_done_last)) && (n < budget)) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_pending", 32'(exp_q.size()), 32'd0);
    endtask

    int t0;
    int wrap_tab [8] = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; base_a = '0; len_a = '0;
        start_b = 1'b0; base_b = '0; len_b = '0;
        m_active = 1'b0; m_done_last = -1; m_start_cyc = 0;
        m_base = 0; m_len = 0; m_issued = 0; m_popped = 0;
        for (int i = 0; i < D; i++) ram[i] = W'(i + 'h100);

        // Reset state
        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_valid", 32'(sa.valid_out), 32'd0);
        chk("rst_last", 32'(sa.last_out), 32'd0);
        chk("rst_ena", 32'(ena_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_data", 32'(sa.data_out), 32'd0);
        chk("rst_regcea", 32'(regcea_a), 32'd0);
        chk("rst_wea", 32'(wea_a), 32'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("regcea_run", 32'(regcea_a), 32'd1);

        // Basic stream: base 5, len 8, ready held high
        rmode = 0;
        @(posedge clk); #1;
        t0 = cyc;
        kick(5, 8);
        wait_idle(100);
        @(negedge clk); #1;
        chk("basic_first_ena", 32'(first_ena), 32'(t0 + 1));
        chk("basic_last_ena", 32'(last_ena), 32'(t0 + 8));
        chk("basic_ena_cnt", 32'(ena_cnt), 32'd8);
        chk("basic_first_valid", 32'(first_valid), 32'(t0 + 4));
        chk("basic_last_pop", 32'(last_pop_cyc), 32'(t0 + 11));
        chk("basic_done", 32'(done_seen), 32'(t0 + 12));
        chk("basic_first_beat", 32'(first_data), 32'h105);
        chk("basic_last_beat", 32'(last_data), 32'h10C);
        chk("basic_busy_after", 32'(busy_a), 32'd0);
        @(posedge clk); #1;

        // Low-latency instance, same stimulus
        t0 = cyc;
        start_b = 1'b1; base_b = AW'(5); len_b = (AW + 1)'(8);
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("b_beats", 32'(bq.size()), 32'd8);
        for (int i = 0; i < 8 && i < bq.size(); i++) begin
            chk("b_cycle", 32'(bq[i].c), 32'(t0 + 3 + i));
            chk("b_data", 32'(bq[i].d), 32'('h105 + i));
            chk("b_last", 32'(bq[i].l), 32'(i == 7));
        end
        chk("b_first_ena", 32'(b_first_ena), 32'(t0 + 1));
        chk("b_done", 32'(b_done_seen), 32'(t0 + 11));

        // Backpressure with ready pattern 1,0,0,1
        rmode = 1;
        kick(0, 16);
        wait_idle(300);

        // Ready held low: exactly FIFO_DEPTH reads, then nothing
        rmode = 3;
        kick(100, 12);
        repeat (20) @(posedge clk);
        #1;
        chk("stall_issues", 32'(ena_cnt), 32'd4);
        chk("stall_valid", 32'(sa.valid_out), 32'd1);
        rmode = 0;
        wait_idle(100);

        // Wrap past the top of the RAM
        rmode = 2;
        kick(1020, 8);
        wait_idle(200);
        chk("wrap_count", 32'(addr_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
            chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_tab[i]));
        end

        // Zero length
        t0 = cyc;
        kick(7, 0);
        wait_idle(20);
        @(negedge clk); #1;
        chk("zero_ena_cnt", 32'(ena_cnt), 32'd0);
        chk("zero_done", 32'(done_seen), 32'(t0 + 1));
        @(posedge clk); #1;

        // Start pulsed mid-transfer must be ignored
        rmode = 1;
        kick(200, 10);
        repeat (3) @(posedge clk);
        #1;
        start_a = 1'b1; base_a = AW'(50); len_a = (AW + 1)'(3);
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_idle(200);

        // Reset in the middle of a transfer
        rmode = 0;
        kick(0, 16);
        begin
            int n;
            n = 0;
            while ((m_popped < 3) && (n < 50)) begin
                @(negedge clk);
                n++;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_done", 32'(done_a), 32'd0);
        chk("arst_valid", 32'(sa.valid_out), 32'd0);
        chk("arst_last", 32'(sa.last_out), 32'd0);
        chk("arst_ena", 32'(ena_a), 32'd0);
        chk("arst_addr", 32'(addr_a), 32'd0);
        chk("arst_data", 32'(sa.data_out), 32'd0);
        chk("arst_regcea", 32'(regcea_a), 32'd0);
        exp_q.delete();
        done_at.delete();
        m_active = 1'b0; m_done_last = -1; m_issued = 0; m_popped = 0; m_len = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        kick(0, 4);
        wait_idle(50);
        chk("post_reset_beats", 32'(m_popped), 32'd4);

        // Randomised transfers, each started in the done cycle of the previous
        for (int i = 0; i < D; i++) ram[i] = W'($urandom());
        rmode = 2;
        for (int t = 0; t < 24; t++) begin
            int b, l;
            b = $urandom_range(0, D - 1);
            l = (t == 0) ? D : $urandom_range(0, 40);
            kick(b, l);
            wait_idle(l * 10 + 50);
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side sequencer that sits directly downstream of the single-port read-first block RAM and converts its fixed-latency, non-stallable read port into a valid/ready stream. Given a base address and word count, it issues RAM reads, tracks the in-flight pipeline, and buffers returned words in a small FIFO so that downstream backpressure never loses or duplicates data. Typical use is streaming stored frame or lookup data to the display and processing pipeline.

## Interface
- RAM_WIDTH, 18, data word width; matches the RAM.
- RAM_DEPTH, 1024, RAM entries; need not be a power of two.
- ADDR_W, 10, RAM address width; must equal ceil(log2(RAM_DEPTH)).
- READ_LATENCY, 2, RAM read latency: 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
- FIFO_DEPTH, 4, output FIFO entries; power of two and at least READ_LATENCY+2.

Ports:
- clka  in  1  clock; everything is synchronous to the rising edge.
- rsta_n  in  1  reset, asynchronous assert, active-low.
- start_in  in  1  begin a transfer; sampled only in IDLE.
- base_addr_in  in  ADDR_W  first address; must be less than RAM_DEPTH.
- len_in  in  ADDR_W+1  word count, 0..RAM_DEPTH.
- busy_out  out  1  high whenever the state is not IDLE.
- done_out  out  1  one-cycle pulse at the end of a transfer.
- ram_addra_out  out  ADDR_W  RAM address.
- ram_ena_out  out  1  RAM enable; high exactly on issue cycles.
- ram_wea_out  out  1  tied 0.
- ram_regcea_out  out  1  1 while rsta_n is high.
- ram_rsta_out  out  1  tied 0.
- ram_douta_in  in  RAM_WIDTH  RAM read data.
- data_out  out  RAM_WIDTH  stream data (FIFO head).
- valid_out  out  1  stream valid.
- last_out  out  1  marks the final word of the transfer; qualified by valid_out.
- ready_in  in  1  downstream accept.

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
- **IDLE**
  - start_in=1 and len_in>0: latch the base address and length, then go to ISSUE.
  - start_in=1 and len_in=0: pulse done_out next cycle and remain in IDLE.
  - start_in is ignored in ISSUE and DRAIN.
- **ISSUE**
  - A read is issued in a cycle only when `fifo_count + inflight < FIFO_DEPTH`.
  - An issue drives ram_ena_out=1 with the current address. It then pushes a tag into a READ_LATENCY-deep shift register; the tag is a valid bit plus a last bit.
  - Address increments per issue and wraps to 0 after RAM_DEPTH-1 (comparison-based wrap, not a mask).
  - The issue of word len-1 sets its last tag and moves the FSM to DRAIN.
- **Capture:** when a tag exits the shift register, ram_douta_in and the tag's last bit are written into the FIFO. Capture never stalls; the credit rule guarantees the FIFO cannot overflow.
- **Output:** valid_out = FIFO not empty. A pop occurs on valid_out & ready_in. data_out and last_out hold stable while valid_out=1 and ready_in=0.
- **DRAIN:** issues nothing. On the pop of the last-tagged word, go to IDLE and pulse done_out in the following cycle.
- **Simultaneous push and pop** in the same cycle is legal at any occupancy, including a full FIFO; fifo_count is unchanged.
- **Reset:** asserting rsta_n mid-operation immediately forces the following:
  - state IDLE;
  - tags cleared, so stale RAM output is never captured;
  - FIFO empty;
  - all outputs 0 except ram_regcea_out, which goes 0 while rsta_n is low.
- **Reset values:** busy_out, done_out, valid_out, last_out, ram_ena_out, ram_addra_out and data_out are all 0.

## Timing
- start_in is sampled at edge T. The first issue, with ram_ena_out high, is cycle T+1.
- A word issued in cycle I is present on ram_douta_in in cycle I+READ_LATENCY, captured at the end of that cycle, and shown with valid_out=1 in cycle I+READ_LATENCY+1.
- First-beat latency:
  - READ_LATENCY=2: valid_out first high in cycle T+4.
  - READ_LATENCY=1: valid_out first high in cycle T+3.
- With ready_in held at 1, the block issues one read per cycle and delivers one beat per cycle with no bubbles.
- With ready_in held at 0, exactly FIFO_DEPTH reads are issued, then ram_ena_out stays 0.
- done_out is high in the first IDLE cycle. A start_in presented in that same cycle is accepted.

## Test plan
- **Basic stream:** RAM[i]=i+0x100, base=5, len=8, ready_in=1, start at T.
  - ram_ena_out high during T+1..T+8.
  - Beats 0x105..0x10C on consecutive cycles from T+4; last_out on 0x10C.
  - done_out at T+12; busy_out low from T+12.
- **Backpressure:** same RAM contents, base=0, len=16, ready_in toggling in the pattern 1,0,0,1.
  - All 16 words arrive in order with no duplicates.
  - Occupancy (fifo_count + inflight) never exceeds 4.
  - data_out stable whenever valid_out=1 and ready_in=0.
- **Wrap:** base=1020, len=8. Addresses issued are 1020, 1021, 1022, 1023, 0, 1, 2, 3; data matches.
- **Zero length and busy start:**
  - len=0: no ram_ena_out, done_out at T+1, valid_out never asserted.
  - A second start_in pulsed mid-transfer has no effect.
- **Reset mid-run:** drop rsta_n after 3 beats.
  - All outputs go to 0 asynchronously.
  - After release, a new start with base=0, len=4 yields exactly RAM[0..3] with no stale beat.
- **Low-latency build:** READ_LATENCY=1 with the RAM in LOW_LATENCY mode, basic-stream stimulus. First beat at T+3, gap-free.
